// File: rtl/uart_receiver.sv
// UART receive stage: 1 start, {parity, data[6:0]} MSB-first, 1 stop, odd parity.
// Oversamples a double-synchronised rx on rx_en ticks; words leave through a valid/ack handshake.
module uart_receiver #(
   parameter int OVS   = 16,
   parameter int CNT_W = 4
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       rx,
   input  logic       rx_en,
   output logic [6:0] data_out,
   output logic       data_valid,
   input  logic       data_ack,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVS / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVS - 1);

   state_t           state_q;
   state_t           state_d;
   logic             rx_meta_q;
   logic             rx_s_q;
   logic [CNT_W-1:0] tick_cnt_q;
   logic [CNT_W-1:0] tick_cnt_d;
   logic [2:0]       bit_cnt_q;
   logic [2:0]       bit_cnt_d;
   logic [7:0]       shreg_q;
   logic [7:0]       shreg_d;

   logic [6:0]       data_out_q;
   logic [6:0]       data_out_d;
   logic             data_valid_q;
   logic             data_valid_d;
   logic             parity_err_q;
   logic             parity_err_d;
   logic             frame_err_q;
   logic             frame_err_d;
   logic             overrun_q;
   logic             overrun_d;

   logic             bit_done;
   logic             commit;

   // Two-flop synchroniser; the line idles high so reset to 1.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // State and sampling datapath registers.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      if (rx_en) begin
         case (state_q)
            IDLE: begin
               if (!rx_s_q) begin
                  state_d    = START;
                  tick_cnt_d = '0;
               end
            end
            START: begin
               if (tick_cnt_q == HALF_LAST) begin
                  tick_cnt_d = '0;
                  bit_cnt_d  = '0;
                  // A line already back high at mid start bit is a glitch.
                  state_d    = rx_s_q ? IDLE : DATA;
               end else begin
                  tick_cnt_d = tick_cnt_q + CNT_W'(1);
               end
            end
            DATA: begin
               if (tick_cnt_q == BIT_LAST) begin
                  tick_cnt_d = '0;
                  shreg_d    = {shreg_q[6:0], rx_s_q};
                  bit_cnt_d  = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = STOP;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + CNT_W'(1);
               end
            end
            STOP: begin
               if (tick_cnt_q == BIT_LAST) begin
                  tick_cnt_d = '0;
                  state_d    = IDLE;
               end else begin
                  tick_cnt_d = tick_cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_comb begin
      busy     = (state_q != IDLE);
      bit_done = rx_en && (tick_cnt_q == BIT_LAST);
      commit   = bit_done && (state_q == STOP);
   end

   // Handshake: a commit always wins over an ack on the same edge.
   always_comb begin
      data_out_d   = data_out_q;
      data_valid_d = data_valid_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      overrun_d    = overrun_q;
      if (commit) begin
         data_out_d   = shreg_q[6:0];
         parity_err_d = ~^shreg_q;
         frame_err_d  = ~rx_s_q;
         data_valid_d = 1'b1;
         if (data_valid_q && !data_ack) begin
            overrun_d = 1'b1;
         end
      end else if (data_valid_q && data_ack) begin
         data_valid_d = 1'b0;
         parity_err_d = 1'b0;
         frame_err_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: the line driver queues the word each frame should present,
// a monitor pops, compares and acks whenever data_valid is up.
module tb_uart_receiver;

   localparam int OVS      = 16;
   localparam int CNT_W    = 4;
   localparam int BIT_CLKS = OVS * 4;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       rx = 1'b1;
   logic       rx_en = 1'b0;
   logic       data_ack = 1'b0;
   logic [6:0] data_out;
   logic       data_valid;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   typedef struct packed {
      logic [6:0] d;
      logic       pe;
      logic       fe;
      logic       ov;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passed = 0;
   bit   hold_ack = 1'b0;

   uart_receiver #(.OVS(OVS), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .resetN     (resetN),
      .rx         (rx),
      .rx_en      (rx_en),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ack   (data_ack),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Oversample strobe: one clk out of every four.
   initial begin : tick_gen
      int c;
      c = 0;
      forever begin
         @(negedge clk);
         rx_en = (c == 3);
         c = (c + 1) % 4;
      end
   end

   initial begin : watchdog
      #(700000);
      $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passed);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference: odd parity bit makes the XOR of all 8 line bits 1; the receiver flags an error
   // when that XOR is 0 and a frame error when the stop bit is 0.
   task automatic send_frame(input logic [6:0] d, input bit bad_par, input bit stop_bit,
                             input bit push, input bit ov);
      logic [7:0] bits;
      exp_t       e;
      bits = {(~^d) ^ bad_par, d};
      if (push) begin
         e.d  = d;
         e.pe = ((^bits) == 1'b0);
         e.fe = (stop_bit == 1'b0);
         e.ov = ov;
         exp_q.push_back(e);
      end
      rx = 1'b0;
      hold(BIT_CLKS);
      for (int i = 7; i >= 0; i--) begin
         rx = bits[i];
         hold(BIT_CLKS);
      end
      rx = stop_bit;
      hold(BIT_CLKS);
      rx = 1'b1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || data_valid || busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n < 3000) passed++;
      else $display("FAIL drain_timeout: got %0d pending words expected 0", exp_q.size());
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (data_valid && !hold_ack) begin
            $display("word data=%02h perr=%0b ferr=%0b ovr=%0b", data_out, parity_err, frame_err, overrun);
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_word: got data_valid=1 with data %02h expected no word", data_out);
            end else begin
               e = exp_q.pop_front();
               chk("data_out", 32'(data_out), 32'(e.d));
               chk("parity_err", 32'(parity_err), 32'(e.pe));
               chk("frame_err", 32'(frame_err), 32'(e.fe));
               chk("overrun", 32'(overrun), 32'(e.ov));
            end
            data_ack = 1'b1;
            @(negedge clk);
            data_ack = 1'b0;
            chk("ack_clears_valid", 32'(data_valid), 32'(0));
            chk("ack_clears_flags", 32'({parity_err, frame_err}), 32'(0));
         end
      end
   end

   initial begin : stimulus
      logic [7:0] bits;
      bit         busy_seen;
      logic [6:0] d;
      bit         bp;
      bit         sb;

      hold(5);
      chk("reset_outputs", 32'({data_out, data_valid, parity_err, frame_err, overrun, busy}), 32'(0));
      resetN = 1'b1;
      hold(20);

      // 1: clean 7'h41
      send_frame(7'h41, 1'b0, 1'b1, 1'b1, 1'b0);
      wait_idle();
      // 2: parity forced wrong
      send_frame(7'h41, 1'b1, 1'b1, 1'b1, 1'b0);
      wait_idle();
      // 3: stop bit low, then a following good frame
      send_frame(7'h7F, 1'b0, 1'b0, 1'b1, 1'b0);
      hold(2 * BIT_CLKS);
      wait_idle();
      send_frame(7'h15, 1'b0, 1'b1, 1'b1, 1'b0);
      wait_idle();

      // 4: short low glitch
      busy_seen = 1'b0;
      rx = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (busy) busy_seen = 1'b1;
      end
      rx = 1'b1;
      for (int i = 0; i < 84; i++) begin
         @(negedge clk);
         if (busy) busy_seen = 1'b1;
      end
      chk("glitch_busy_pulse", 32'(busy_seen), 32'(1));
      chk("glitch_back_idle", 32'({busy, data_valid}), 32'(0));

      // 5: reset during bit 3, then a clean 7'h2A
      bits = {~^7'h2A, 7'h2A};
      rx = 1'b0;
      hold(BIT_CLKS);
      for (int i = 7; i >= 5; i--) begin
         rx = bits[i];
         hold(BIT_CLKS);
      end
      rx = bits[4];
      hold(BIT_CLKS / 2);
      chk("busy_mid_frame", 32'(busy), 32'(1));
      resetN = 1'b0;
      rx = 1'b1;
      @(negedge clk);
      chk("midframe_reset_outputs", 32'({data_out, data_valid, parity_err, frame_err, overrun, busy}), 32'(0));
      resetN = 1'b1;
      hold(2 * BIT_CLKS);
      chk("no_word_after_reset", 32'(data_valid), 32'(0));
      send_frame(7'h2A, 1'b0, 1'b1, 1'b1, 1'b0);
      wait_idle();

      // Randomised frames
      for (int k = 0; k < 10; k++) begin
         d  = 7'($urandom_range(0, 127));
         bp = ($urandom_range(0, 3) == 0);
         sb = ($urandom_range(0, 4) != 0);
         send_frame(d, bp, sb, 1'b1, 1'b0);
         if (!sb) hold(2 * BIT_CLKS);
         else hold($urandom_range(0, 40));
         wait_idle();
      end

      // 6: two frames with no ack; the second overwrites and sets overrun
      hold_ack = 1'b1;
      send_frame(7'h01, 1'b0, 1'b1, 1'b0, 1'b0);
      send_frame(7'h02, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("overrun_set", 32'(overrun), 32'(1));
      chk("overrun_word", 32'(data_out), 32'(7'h02));
      hold_ack = 1'b0;
      wait_idle();
      hold(BIT_CLKS);
      chk("overrun_sticky", 32'(overrun), 32'(1));
      resetN = 1'b0;
      @(negedge clk);
      chk("overrun_reset", 32'({overrun, data_valid, data_out}), 32'(0));
      resetN = 1'b1;
      hold(10);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
